// File: rtl/cnt_sync_ctrl.sv
// Fast-domain scheduler for a slow-domain counter: toggle request in, settle,
// double-sample until stable, publish with a valid pulse and an ack toggle.
module cnt_sync_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] count_src,
    output logic [WIDTH-1:0] count_out,
    output logic             count_vld,
    output logic             ack_tgl,
    output logic             mismatch,
    output logic             overrun,
    output logic             stall,
    output logic             busy
);

    localparam int IW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;

    logic [1:0]       state;
    logic             req_q;
    logic             pending;
    logic [3:0]       wait_cnt;
    logic [IW-1:0]    idle_cnt;
    logic [WIDTH-1:0] sample_a;
    logic             req_edge;

    assign req_edge = req_tgl ^ req_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            req_q     <= 1'b0;
            pending   <= 1'b0;
            wait_cnt  <= '0;
            idle_cnt  <= '0;
            sample_a  <= '0;
            count_out <= '0;
            count_vld <= 1'b0;
            ack_tgl   <= 1'b0;
            mismatch  <= 1'b0;
            overrun   <= 1'b0;
            stall     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            req_q     <= req_tgl;
            count_vld <= 1'b0;
            mismatch  <= 1'b0;
            if (!en)
                idle_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (en && (req_edge || pending)) begin
                        state    <= S_SETTLE;
                        busy     <= 1'b1;
                        wait_cnt <= 4'(SETTLE);
                        // a fresh edge arriving while a held request is consumed stays queued
                        pending  <= pending && req_edge;
                        stall    <= 1'b0;
                        idle_cnt <= '0;
                    end else if (en) begin
                        if (idle_cnt == IW'(TIMEOUT - 1))
                            stall <= 1'b1;
                        else
                            idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                S_SETTLE: begin
                    if (wait_cnt == 4'd0) begin
                        sample_a <= count_src;
                        state    <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    if (count_src == sample_a) begin
                        count_out <= sample_a;
                        count_vld <= 1'b1;
                        ack_tgl   <= ~ack_tgl;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                    end else begin
                        mismatch  <= 1'b1;
                        wait_cnt  <= 4'(SETTLE);
                        state     <= S_SETTLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // requests during a transfer queue one deep; a second one is lost
            if (state != S_IDLE && req_edge) begin
                if (pending)
                    overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end
        end
    end

endmodule
